df_pingpong_buf: RTL and testbench
==================================

DF_PINGPONG_BUF -- requirements
Module: df_pingpong_buf

Interface
REQ-001 Parameter PIX_W, default 8, bits per pixel.
REQ-002 Parameter BLK_NUM, default 26, 4x4 blocks per macroblock bank (legal 1..32).
REQ-003 Parameter ADDR_W, default 5, RAM address width; BLK_NUM <= 2^ADDR_W.
REQ-004 Ports (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge.
  reset_n  in  1  asynchronous active-low reset.
  wr_valid  in  1  reconstruction writes one 4x4 block this cycle.
  wr_ready  out  1  a bank is available for writing.
  wr_addr  in  ADDR_W  block index.
  wr_data  in  16*PIX_W  block, raster order, pixel 00 in MSBs.
  wr_mb_done  in  1  pulse: current write bank complete.
  rd_req  in  1  deblocking reads one row this cycle.
  rd_addr  in  ADDR_W  block index.
  rd_row  in  2  row 0..3 of block.
  rd_mb_done  in  1  pulse: current read bank consumed.
  rd_avail  out  1  a full bank is ready for reading.
  rd_valid  out  1  rd_data valid.
  rd_data  out  4*PIX_W  selected row, pixel 0 in MSBs.
  ramN_wr_n, ramN_rd_n  out  1  bank N (N=0,1) active-low strobes.
  ramN_addr  out  ADDR_W  bank N address.
  ramN_din  out  16*PIX_W  bank N write data.
  ramN_dout  in  16*PIX_W  bank N read data, valid one cycle after ramN_rd_n low.
  err  out  1  sticky protocol error (REQ-020).

Function
REQ-005 Each bank SHALL hold state EMPTY, FULL or READING; writer owns bank wsel, reader owns bank rsel.
REQ-006 wr_ready SHALL be 1 iff bank wsel is EMPTY.
REQ-007 wr_valid with wr_ready=1 SHALL drive ram[wsel]_wr_n=0, addr=wr_addr, din=wr_data combinationally in that cycle; wr_valid with wr_ready=0 SHALL be dropped.
REQ-008 wr_mb_done with wr_ready=1 SHALL set bank wsel FULL and toggle wsel on the next edge.
REQ-009 rd_avail SHALL be 1 iff bank rsel is FULL or READING.
REQ-010 First rd_req on a FULL bank SHALL move it to READING.
REQ-011 rd_req with rd_avail=1 SHALL drive ram[rsel]_rd_n=0 and addr=rd_addr combinationally; rd_row and rsel SHALL be registered.
REQ-012 rd_data SHALL be registered: request at edge N yields rd_valid=1 and the requested row at edge N+2; back-to-back requests give one row per cycle.
REQ-013 rd_mb_done SHALL set bank rsel EMPTY and toggle rsel on the next edge; reads in flight SHALL still complete.
REQ-014 wr_mb_done and rd_mb_done in the same cycle SHALL both take effect.
REQ-015 Idle bank strobes SHALL be 1; idle addr and din SHALL be 0.
REQ-016 wr_addr or rd_addr >= BLK_NUM SHALL be ignored and SHALL set err.

Reset
REQ-017 On reset_n=0, asynchronously: both banks EMPTY, wsel=0, rsel=0, rd_valid=0, rd_data=0, err=0, rd_avail=0, wr_ready=1.
REQ-018 Reset mid-operation SHALL discard all bank contents and in-flight reads; rd_valid SHALL be 0 on the first edge after release.
REQ-019 All RAM strobes SHALL be 1 while reset_n=0.

Configuration
REQ-020 With DF_PINGPONG_ERR_EN defined: err also SET by rd_req with rd_avail=0, wr_valid with wr_ready=0, rd_mb_done on a non-READING bank, or wr_mb_done with wr_ready=0; without it, those events are silently ignored and err sets only per REQ-016.

Verification
REQ-021 Write blocks 0..25 (block k = all pixels k) and wr_mb_done -> wr_ready=1, rd_avail=1 on next cycle.
REQ-022 After REQ-021, rd_req addr=3 row=2 at edge N -> rd_valid=1, rd_data=0x03030303 at N+2.
REQ-023 Fill both banks without rd_mb_done -> wr_ready=0; 27th wr_valid issues no bank-0 or bank-1 strobe.
REQ-024 Simultaneous wr_mb_done (bank 1) and rd_mb_done (bank 0) -> bank 0 EMPTY, bank 1 FULL, wsel=0, rsel=1.
REQ-025 reset_n low for one cycle between two reads -> rd_valid=0, rd_avail=0, wr_ready=1 on the next edge.
REQ-026 rd_req with rd_avail=0 -> err=1 with DF_PINGPONG_ERR_EN defined, err=0 without.

Source files
------------

// File: rtl/df_pingpong_buf.sv
// ----------------------------------------------------------------------------
// df_pingpong_buf
//   Two-bank ping-pong buffer between H.264-style reconstruction (writer, one
//   4x4 block per cycle) and the deblocking filter (reader, one 4-pixel row
//   per cycle). Each bank holds BLK_NUM blocks in an external single-port RAM
//   driven through active-low strobes. The writer fills bank wsel while the
//   reader drains bank rsel; wr_mb_done / rd_mb_done hand banks across.
//
//   Parameters
//     PIX_W   bits per pixel
//     BLK_NUM blocks per bank (1..32)
//     ADDR_W  RAM address width, BLK_NUM <= 2**ADDR_W
//
//   Ports
//     clk, reset_n                 clock, async active-low reset
//     wr_valid/wr_ready/wr_addr/wr_data/wr_mb_done   writer side
//     rd_req/rd_addr/rd_row/rd_mb_done/rd_avail      reader request side
//     rd_valid/rd_data             registered row, 2 cycles after request
//     ram{0,1}_wr_n/_rd_n/_addr/_din/_dout           external bank RAMs
//     err                          sticky protocol error
//
//   Build option
//     DF_PINGPONG_ERR_EN  when defined, handshake violations (request on an
//     unavailable bank, early mb_done) also set err; otherwise only
//     out-of-range block addresses do.
// ----------------------------------------------------------------------------

// Per-bank slice: ownership state machine plus the RAM port mux.
module df_pp_bank #(
    parameter int ADDR_W = 5,
    parameter int BLK_W  = 128
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_own,     // this bank is bank wsel
    input  logic              rd_own,     // this bank is bank rsel
    input  logic              wr_fire,
    input  logic              rd_fire,
    input  logic              wr_done,
    input  logic              rd_done,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BLK_W-1:0]  wr_data,
    output logic              is_empty,
    output logic              is_full,
    output logic              is_reading,
    output logic              ram_wr_n,
    output logic              ram_rd_n,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [BLK_W-1:0]  ram_din
);
    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_READING = 2'd2
    } bank_st_e;

    bank_st_e state_q, state_d;
    logic     wr_hit, rd_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    // Writer and reader never own the same bank in a legal state (writer
    // needs EMPTY, reader needs FULL/READING), so transitions cannot collide.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY:   if (wr_own && wr_done) state_d = ST_FULL;
            ST_FULL:    if (rd_own && rd_fire) state_d = ST_READING;
            ST_READING: if (rd_own && rd_done) state_d = ST_EMPTY;
            default:    state_d = ST_EMPTY;
        endcase
    end

    assign is_empty   = (state_q == ST_EMPTY);
    assign is_full    = (state_q == ST_FULL);
    assign is_reading = (state_q == ST_READING);

    // Strobes are forced high while reset is asserted, independent of inputs.
    assign wr_hit   = reset_n & wr_own & wr_fire;
    assign rd_hit   = reset_n & rd_own & rd_fire;
    assign ram_wr_n = ~wr_hit;
    assign ram_rd_n = ~rd_hit;
    assign ram_addr = wr_hit ? wr_addr : (rd_hit ? rd_addr : '0);
    assign ram_din  = wr_hit ? wr_data : '0;
endmodule

module df_pingpong_buf #(
    parameter int PIX_W   = 8,
    parameter int BLK_NUM = 26,
    parameter int ADDR_W  = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [16*PIX_W-1:0] wr_data,
    input  logic                wr_mb_done,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [1:0]          rd_row,
    input  logic                rd_mb_done,
    output logic                rd_avail,
    output logic                rd_valid,
    output logic [4*PIX_W-1:0]  rd_data,
    output logic                ram0_wr_n,
    output logic                ram0_rd_n,
    output logic [ADDR_W-1:0]   ram0_addr,
    output logic [16*PIX_W-1:0] ram0_din,
    input  logic [16*PIX_W-1:0] ram0_dout,
    output logic                ram1_wr_n,
    output logic                ram1_rd_n,
    output logic [ADDR_W-1:0]   ram1_addr,
    output logic [16*PIX_W-1:0] ram1_din,
    input  logic [16*PIX_W-1:0] ram1_dout,
    output logic                err
);
    localparam int BLK_W     = 16 * PIX_W;
    localparam int ROW_W     = 4 * PIX_W;
    localparam int NUM_BANKS = 2;
    localparam int RD_STAGES = 1;   // vld_pipe[0]: RAM access, [1]: rd_data

    typedef struct packed {
        logic       bank;
        logic [1:0] row;
    } rd_tag_t;

    logic                    wsel, rsel;
    logic [NUM_BANKS-1:0]    bank_empty, bank_full, bank_reading;
    logic [NUM_BANKS-1:0]    ram_wr_n_v, ram_rd_n_v;
    logic [ADDR_W-1:0]       ram_addr_v [NUM_BANKS];
    logic [BLK_W-1:0]        ram_din_v  [NUM_BANKS];
    logic                    wr_addr_ok, rd_addr_ok;
    logic                    wr_fire, rd_fire, wr_done_ok, rd_done_ok;
    logic                    err_set;
    logic [RD_STAGES:0]      vld_pipe;
    rd_tag_t                 tag_q;
    logic [3:0][ROW_W-1:0]   blk_rows;

    assign wr_addr_ok = (int'(wr_addr) < BLK_NUM);
    assign rd_addr_ok = (int'(rd_addr) < BLK_NUM);

    assign wr_ready = bank_empty[wsel];
    assign rd_avail = bank_full[rsel] | bank_reading[rsel];

    assign wr_fire    = wr_valid & wr_ready & wr_addr_ok;
    assign rd_fire    = rd_req & rd_avail & rd_addr_ok;
    assign wr_done_ok = wr_mb_done & wr_ready;
    // A bank is only released once the reader has actually started on it.
    assign rd_done_ok = rd_mb_done & bank_reading[rsel];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        localparam logic ID = (b == 1);
        df_pp_bank #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) u_bank (
            .clk        (clk),
            .reset_n    (reset_n),
            .wr_own     (wsel == ID),
            .rd_own     (rsel == ID),
            .wr_fire    (wr_fire),
            .rd_fire    (rd_fire),
            .wr_done    (wr_done_ok),
            .rd_done    (rd_done_ok),
            .wr_addr    (wr_addr),
            .rd_addr    (rd_addr),
            .wr_data    (wr_data),
            .is_empty   (bank_empty[b]),
            .is_full    (bank_full[b]),
            .is_reading (bank_reading[b]),
            .ram_wr_n   (ram_wr_n_v[b]),
            .ram_rd_n   (ram_rd_n_v[b]),
            .ram_addr   (ram_addr_v[b]),
            .ram_din    (ram_din_v[b])
        );
    end

    assign ram0_wr_n = ram_wr_n_v[0];
    assign ram0_rd_n = ram_rd_n_v[0];
    assign ram0_addr = ram_addr_v[0];
    assign ram0_din  = ram_din_v[0];
    assign ram1_wr_n = ram_wr_n_v[1];
    assign ram1_rd_n = ram_rd_n_v[1];
    assign ram1_addr = ram_addr_v[1];
    assign ram1_din  = ram_din_v[1];

    // Bank selects. wr_mb_done and rd_mb_done act on different banks, so
    // both may land in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wsel <= 1'b0;
            rsel <= 1'b0;
        end else begin
            if (wr_done_ok) wsel <= ~wsel;
            if (rd_done_ok) rsel <= ~rsel;
        end
    end

    // Read pipeline. The tag remembers which bank/row was asked for so that
    // a read issued just before rd_mb_done still returns the old bank's row.
    // Row 0 sits in the block MSBs, hence the inverted row index.
    assign blk_rows = tag_q.bank ? ram1_dout : ram0_dout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            tag_q    <= '0;
            rd_data  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_STAGES-1:0], rd_fire};
            if (rd_fire)     tag_q   <= '{bank: rsel, row: rd_row};
            if (vld_pipe[0]) rd_data <= blk_rows[~tag_q.row];
        end
    end

    assign rd_valid = vld_pipe[RD_STAGES];

    always_comb begin
        err_set = (wr_valid & ~wr_addr_ok) | (rd_req & ~rd_addr_ok);
`ifdef DF_PINGPONG_ERR_EN
        err_set = err_set
                | (rd_req     & ~rd_avail)
                | (wr_valid   & ~wr_ready)
                | (rd_mb_done & ~bank_reading[rsel])
                | (wr_mb_done & ~wr_ready);
`else
        err_set = err_set;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end
endmodule

// File: tb/tb_df_pingpong_buf.sv
module tb_df_pingpong_buf;
    localparam int PIX_W = 8;
    localparam int ADDR_W = 5;
`ifdef DF_PINGPONG_ERR_EN
    localparam logic ERRV = 1'b1;
`else
    localparam logic ERRV = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         wr_valid, wr_ready, wr_mb_done;
    logic [4:0]   wr_addr;
    logic [127:0] wr_data;
    logic         rd_req, rd_mb_done, rd_avail, rd_valid;
    logic [4:0]   rd_addr;
    logic [1:0]   rd_row;
    logic [31:0]  rd_data;
    logic         ram0_wr_n, ram0_rd_n, ram1_wr_n, ram1_rd_n;
    logic [4:0]   ram0_addr, ram1_addr;
    logic [127:0] ram0_din, ram1_din, ram0_dout, ram1_dout;
    logic         err;

    int vec = 0;
    int mis = 0;
    logic [31:0] exp_q[$];

    df_pingpong_buf #(.PIX_W(PIX_W), .BLK_NUM(26), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mb_done(wr_mb_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_row(rd_row),
        .rd_mb_done(rd_mb_done), .rd_avail(rd_avail), .rd_valid(rd_valid),
        .rd_data(rd_data),
        .ram0_wr_n(ram0_wr_n), .ram0_rd_n(ram0_rd_n), .ram0_addr(ram0_addr),
        .ram0_din(ram0_din), .ram0_dout(ram0_dout),
        .ram1_wr_n(ram1_wr_n), .ram1_rd_n(ram1_rd_n), .ram1_addr(ram1_addr),
        .ram1_din(ram1_din), .ram1_dout(ram1_dout),
        .err(err)
    );

    always #5 clk = ~clk;

    // Synchronous RAMs: dout valid one cycle after rd_n low.
    logic [127:0] mem0 [32];
    logic [127:0] mem1 [32];
    always @(posedge clk) begin
        if (!ram0_wr_n) mem0[ram0_addr] <= ram0_din;
        if (!ram0_rd_n) ram0_dout <= mem0[ram0_addr];
        if (!ram1_wr_n) mem1[ram1_addr] <= ram1_din;
        if (!ram1_rd_n) ram1_dout <= mem1[ram1_addr];
    end

    function automatic logic [7:0] pix(input int mode, input int k, input int p);
        case (mode)
            0:       return 8'(k);
            1:       return 8'(k + 16 * p);
            default: return 8'(200 - k - 13 * p);
        endcase
    endfunction

    function automatic logic [127:0] blk(input int mode, input int k);
        logic [127:0] d;
        for (int p = 0; p < 16; p++) d[127-8*p -: 8] = pix(mode, k, p);
        return d;
    endfunction

    function automatic logic [31:0] row(input int mode, input int k, input int r);
        logic [127:0] d;
        d = blk(mode, k);
        return d[127-32*r -: 32];
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vec++;
        assert (obs === exp) else begin
            mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_one(input int a, input int r, input int mode);
        rd_req = 1'b1;
        rd_addr = 5'(a);
        rd_row = 2'(r);
        exp_q.push_back(row(mode, a, r));
        tick();
    endtask

    // Scoreboard: every returned row must match the oldest outstanding one.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) chk1("rd_unexpected", rd_valid, 1'b0);
            else chkw("rd_data", 128'(rd_data), 128'(exp_q.pop_front()));
        end
    end

    initial begin
        reset_n = 1'b0; wr_valid = 1'b1; wr_addr = '0; wr_data = '1;
        wr_mb_done = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_row = '0; rd_mb_done = 1'b0;
        @(negedge clk);
        chk1("rst_wr_ready", wr_ready, 1'b1);
        chk1("rst_rd_avail", rd_avail, 1'b0);
        chk1("rst_rd_valid", rd_valid, 1'b0);
        chkw("rst_rd_data", 128'(rd_data), 128'(0));
        chk1("rst_err", err, 1'b0);
        chk1("rst_ram0_wr_n", ram0_wr_n, 1'b1);
        chk1("rst_ram1_wr_n", ram1_wr_n, 1'b1);
        chk1("rst_ram0_rd_n", ram0_rd_n, 1'b1);
        chk1("rst_ram1_rd_n", ram1_rd_n, 1'b1);
        wr_valid = 1'b0; wr_data = '0;
        tick(); reset_n = 1'b1;
        @(negedge clk);
        chkw("idle_ram0_addr", 128'(ram0_addr), 128'(0));
        chkw("idle_ram0_din", ram0_din, 128'(0));
        chkw("idle_ram1_addr", 128'(ram1_addr), 128'(0));

        // Read request with nothing available
        tick(); rd_req = 1'b1; rd_addr = 5'd0;
        @(negedge clk);
        chk1("noavail_rd_n", ram0_rd_n, 1'b1);
        tick(); rd_req = 1'b0;
        @(negedge clk);
        chk1("noavail_err", err, ERRV);
        tick(); reset_n = 1'b0;
        @(negedge clk);
        chk1("rst_clr_err", err, 1'b0);
        tick(); reset_n = 1'b1;

        // Fill bank 0: block k = all pixels k
        for (int k = 0; k < 26; k++) begin
            wr_valid = 1'b1; wr_addr = 5'(k); wr_data = blk(0, k);
            if (k == 5) begin
                @(negedge clk);
                chk1("wr0_strobe", ram0_wr_n, 1'b0);
                chkw("wr0_addr", 128'(ram0_addr), 128'(5));
                chkw("wr0_din", ram0_din, blk(0, 5));
                chk1("wr0_other", ram1_wr_n, 1'b1);
            end
            tick();
        end
        wr_valid = 1'b0;
        @(negedge clk);
        chk1("pre_done_avail", rd_avail, 1'b0);
        tick(); wr_mb_done = 1'b1;
        tick(); wr_mb_done = 1'b0;
        @(negedge clk);
        chk1("done_wr_ready", wr_ready, 1'b1);
        chk1("done_rd_avail", rd_avail, 1'b1);

        // Latency: request launched after edge N, data valid at edge N+2
        tick();
        rd_req = 1'b1; rd_addr = 5'd3; rd_row = 2'd2;
        exp_q.push_back(32'h03030303);
        @(negedge clk);
        chk1("rd_strobe", ram0_rd_n, 1'b0);
        chkw("rd_addr", 128'(ram0_addr), 128'(3));
        chk1("rd_other", ram1_rd_n, 1'b1);
        tick(); rd_req = 1'b0;
        @(negedge clk);
        chk1("lat_n1", rd_valid, 1'b0);
        tick();
        @(negedge clk);
        chk1("lat_n2", rd_valid, 1'b1);
        chkw("lat_data", 128'(rd_data), 128'(32'h03030303));
        tick();
        rd_one(10, 0, 0); rd_one(25, 3, 0); rd_one(0, 1, 0);
        rd_req = 1'b0;
        tick(); tick(); tick();

        // Fill bank 1 with a row-distinct pattern while reading bank 0
        for (int k = 0; k < 26; k++) begin
            wr_valid = 1'b1; wr_addr = 5'(k); wr_data = blk(1, k);
            if (k == 7) begin
                rd_req = 1'b1; rd_addr = 5'd7; rd_row = 2'd1;
                exp_q.push_back(row(0, 7, 1));
                @(negedge clk);
                chk1("wr1_strobe", ram1_wr_n, 1'b0);
                chkw("wr1_addr", 128'(ram1_addr), 128'(7));
                chkw("wr1_din", ram1_din, blk(1, 7));
                chk1("wr1_other", ram0_wr_n, 1'b1);
                chk1("wr1_rd_strobe", ram0_rd_n, 1'b0);
                chkw("wr1_rd_addr", 128'(ram0_addr), 128'(7));
            end
            tick();
            rd_req = 1'b0;
        end
        wr_valid = 1'b0;

        // In-flight read, then both mb_done pulses together
        rd_req = 1'b1; rd_addr = 5'd20; rd_row = 2'd3;
        exp_q.push_back(row(0, 20, 3));
        tick(); rd_req = 1'b0; wr_mb_done = 1'b1; rd_mb_done = 1'b1;
        tick(); wr_mb_done = 1'b0; rd_mb_done = 1'b0;
        @(negedge clk);
        chk1("swap_wr_ready", wr_ready, 1'b1);
        chk1("swap_rd_avail", rd_avail, 1'b1);
        chk1("swap_err", err, 1'b0);
        tick();
        rd_req = 1'b1; rd_addr = 5'd9; rd_row = 2'd2;
        exp_q.push_back(row(1, 9, 2));
        @(negedge clk);
        chk1("rsel1_strobe", ram1_rd_n, 1'b0);
        chkw("rsel1_addr", 128'(ram1_addr), 128'(9));
        chk1("rsel1_other", ram0_rd_n, 1'b1);
        tick();
        rd_one(0, 0, 1); rd_one(24, 3, 1);
        rd_req = 1'b0;

        // Refill bank 0: both banks now owned by the reader side
        for (int k = 0; k < 26; k++) begin
            wr_valid = 1'b1; wr_addr = 5'(k); wr_data = blk(2, k);
            if (k == 0) begin
                @(negedge clk);
                chk1("wsel0_strobe", ram0_wr_n, 1'b0);
                chk1("wsel0_other", ram1_wr_n, 1'b1);
            end
            tick();
        end
        wr_valid = 1'b0; wr_mb_done = 1'b1;
        tick(); wr_mb_done = 1'b0;
        @(negedge clk);
        chk1("full_wr_ready", wr_ready, 1'b0);
        chk1("full_rd_avail", rd_avail, 1'b1);
        tick();
        wr_valid = 1'b1; wr_addr = 5'd0; wr_data = blk(2, 1);
        @(negedge clk);
        chk1("drop_ram0_wr_n", ram0_wr_n, 1'b1);
        chk1("drop_ram1_wr_n", ram1_wr_n, 1'b1);
        tick(); wr_valid = 1'b0;
        @(negedge clk);
        chk1("drop_err", err, ERRV);
        tick();

        // Reset for one cycle with a read in flight
        rd_one(2, 1, 1);
        rd_req = 1'b0; reset_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk1("rst_mid_valid", rd_valid, 1'b0);
        chk1("rst_mid_strobe", ram1_rd_n, 1'b1);
        tick(); reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk1("post_rst_valid", rd_valid, 1'b0);
        chk1("post_rst_avail", rd_avail, 1'b0);
        chk1("post_rst_wr_ready", wr_ready, 1'b1);
        chk1("post_rst_err", err, 1'b0);
        tick();

        // Out-of-range block index
        wr_valid = 1'b1; wr_addr = 5'd26; wr_data = blk(0, 26);
        @(negedge clk);
        chk1("oor_strobe", ram0_wr_n, 1'b1);
        tick(); wr_valid = 1'b0;
        @(negedge clk);
        chk1("oor_err", err, 1'b1);
        chk1("oor_wr_ready", wr_ready, 1'b1);

        repeat (3) tick();
        chk1("sb_drain", exp_q.size() == 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
